// File: rtl/exotiny_console_mon.sv
// exotiny_console_mon
// Snoops CPU writes to the console register, buffers each written byte in a
// small FIFO for draining, flags pass/fail keywords seen in the byte stream
// and flags a runaway program through a cycle watchdog.
//
// Ports
//   clk_i      clock
//   rst_in     asynchronous active-low reset
//   stb_i      CPU dmem strobe (a rising edge qualifies one capture)
//   sel_i      register-space select from the bus decoder
//   adr_i      register address, compared against CON_ADR
//   dat_i      write data, only [7:0] is captured
//   chr_o      FIFO head byte (0 while empty)
//   chr_vld_o  FIFO non-empty
//   chr_rdy_i  consumer accepts the head byte
//   ovf_o      sticky: a byte was dropped on a full FIFO
//   done_o     sticky: pass keyword seen
//   err_o      sticky: fail keyword seen
//   tmo_o      sticky: watchdog expired
//   cnt_o      bytes captured since reset, saturating
//
// state   | meaning
// --------+--------------------------------------------------
// ST_RUN  | program running, watchdog counting
// ST_PASS | pass keyword seen, terminal until reset
// ST_FAIL | fail keyword seen, terminal until reset
// ST_TMO  | watchdog expired, terminal until reset

module exotiny_console_mon #(
    parameter int             ADR_W     = 5,
    parameter logic [ADR_W-1:0] CON_ADR = 'hC,
    parameter int             DEPTH     = 16,
    parameter logic [31:0]    PASS_WORD = "DONE",
    parameter int             PASS_LEN  = 4,
    parameter logic [31:0]    FAIL_WORD = "ERR",
    parameter int             FAIL_LEN  = 3,
    parameter int unsigned    TIMEOUT   = 600000
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             stb_i,
    input  logic             sel_i,
    input  logic [ADR_W-1:0] adr_i,
    input  logic [31:0]      dat_i,
    output logic [7:0]       chr_o,
    output logic             chr_vld_o,
    input  logic             chr_rdy_i,
    output logic             ovf_o,
    output logic             done_o,
    output logic             err_o,
    output logic             tmo_o,
    output logic [15:0]      cnt_o
);

    localparam int AW = $clog2(DEPTH);
    // Keep only the significant low bytes of each keyword in the compare.
    localparam logic [31:0] PASS_MASK = 32'hFFFF_FFFF >> (8 * (4 - PASS_LEN));
    localparam logic [31:0] FAIL_MASK = 32'hFFFF_FFFF >> (8 * (4 - FAIL_LEN));

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TMO} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_stb_q;
    logic [7:0]    r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [31:0]   r_sreg;
    logic [15:0]   r_cnt;
    logic          r_ovf;
    logic [31:0]   r_wdog;

    logic w_cap;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_pass_hit;
    logic w_fail_hit;
    logic w_wdog_hit;
    logic w_unused_dat;

    // Edge-detect the strobe so a long strobe captures only once.
    assign w_cap   = stb_i & ~r_stb_q & sel_i & (adr_i == CON_ADR);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = ~w_empty & chr_rdy_i;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_push  = w_cap & (~w_full | w_pop);

    assign w_pass_hit = ((r_sreg ^ PASS_WORD) & PASS_MASK) == 32'h0;
    assign w_fail_hit = ((r_sreg ^ FAIL_WORD) & FAIL_MASK) == 32'h0;
    assign w_wdog_hit = (TIMEOUT != 0) && (r_wdog == TIMEOUT - 1);

    assign w_unused_dat = ^dat_i[31:8];

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_stb_q  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_sreg   <= 32'h0;
            r_cnt    <= 16'h0;
            r_ovf    <= 1'b0;
        end else begin
            r_stb_q <= stb_i;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_cap) begin
                r_sreg <= {r_sreg[23:0], dat_i[7:0]};
                if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'h1;
                if (w_full && !w_pop) r_ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= dat_i[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_RUN;
            r_wdog  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_RUN) r_wdog <= r_wdog + 32'h1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_RUN) begin
            if (w_fail_hit)      w_state_nxt = ST_FAIL;
            else if (w_pass_hit) w_state_nxt = ST_PASS;
            else if (w_wdog_hit) w_state_nxt = ST_TMO;
        end
    end

    assign chr_vld_o = ~w_empty;
    assign chr_o     = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign ovf_o     = r_ovf;
    assign cnt_o     = r_cnt;
    assign done_o    = (r_state == ST_PASS);
    assign err_o     = (r_state == ST_FAIL);
    assign tmo_o     = (r_state == ST_TMO);

endmodule
